// File: rtl/hilo_mult_unit.sv
// ---------------------------------------------------------------------------
// hilo_mult_unit
//
// Multi-cycle MULT/MULTU engine that also owns the HI/LO special registers.
// Decode issues an operation with a one-cycle start strobe and stalls while
// busy is high. Multiplies run a radix-2 shift-add over the magnitudes of the
// operands (one multiplier bit per cycle), then a final FIX cycle applies the
// sign and writes the 64-bit product into HI/LO. MTHI/MTLO complete in the
// issue cycle without entering the multiply sequence.
//
// Ports
//   clk     in   processor clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   issue strobe, sampled on rising clk
//   op      in   00 MULT, 01 MULTU, 10 MTHI, 11 MTLO
//   rs_val  in   first operand / MTHI-MTLO source
//   rt_val  in   second operand
//   flush   in   synchronous abort of an in-flight multiply
//   busy    out  multiply in progress (RUN or FIX)
//   done    out  one-cycle pulse when HI/LO take a new product
//   hi      out  HI register
//   lo      out  LO register
// ---------------------------------------------------------------------------
module hilo_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        count;
  logic                 neg;

  logic                 issue_mul;
  logic                 issue_mt;
  logic                 is_signed;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   result;

  // Issue decode and operand conditioning. Only IDLE accepts a start, so a
  // strobe arriving while busy simply falls on the floor. For MULT a negative
  // operand is negated to its magnitude; the most negative value negates to
  // itself, which is still the right unsigned magnitude.
  always_comb begin
    issue_mul = 1'b0;
    issue_mt  = 1'b0;
    is_signed = 1'b0;
    mag_a     = rs_val;
    mag_b     = rt_val;
    result    = acc;

    if (state == IDLE && start) begin
      issue_mul = ~op[1];
      issue_mt  = op[1];
    end

    is_signed = (op == OP_MULT);
    if (is_signed && rs_val[WIDTH-1]) begin
      mag_a = -rs_val;
    end
    if (is_signed && rt_val[WIDTH-1]) begin
      mag_b = -rt_val;
    end

    if (neg) begin
      result = -acc;
    end
  end

  // State register. Reset lands in IDLE regardless of what was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. RUN leaves on the edge where the counter steps from 1
  // to 0, so the counter reads 0 exactly when FIX is entered. flush wins over
  // both the last RUN step and FIX completion.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (issue_mul) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_next = IDLE;
        end else if (count <= CW'(1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and architectural registers. The accumulator only ever holds
  // the unsigned product of the magnitudes; HI/LO are written once, in FIX,
  // so partial products never leak out. MTHI/MTLO write straight through in
  // IDLE. done defaults low so it can only ever be a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (issue_mul) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            count  <= CW'(WIDTH);
            neg    <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
          end else if (issue_mt) begin
            if (op == OP_MTLO) begin
              lo <= rs_val;
            end else begin
              hi <= rs_val;
            end
          end
        end

        RUN: begin
          if (flush) begin
            count <= '0;
          end else begin
            if (mplier[0]) begin
              acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
          end
        end

        FIX: begin
          count <= '0;
          if (!flush) begin
            hi   <= result[2*WIDTH-1:WIDTH];
            lo   <= result[WIDTH-1:0];
            done <= 1'b1;
          end
        end

        default: begin
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/hilo_mult_unit.md
# hilo_mult_unit

Multi-cycle integer multiplier that executes MULT/MULTU and owns the HI/LO special registers read by MFHI/MFLO. It sits beside the EX stage of the pipelined processor. Decode issues an operation with a start pulse and operands, and stalls while `busy` is high. The unit writes the 64-bit product into HI/LO, where the register-file view (`hi`, `lo`) exposes it to the rest of the core and to benches.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits, product is 2×`WIDTH`.
- `clk`  in  1  processor clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe, sampled on rising `clk`.
- `op`  in  2  operation: 00 MULT (signed), 01 MULTU (unsigned), 10 MTHI, 11 MTLO.
- `rs_val`  in  `WIDTH`  first operand; source value for MTHI/MTLO.
- `rt_val`  in  `WIDTH`  second operand.
- `flush`  in  1  synchronous abort of an in-flight multiply.
- `busy`  out  1  multiply in progress; the pipeline must not issue and must stall MFHI/MFLO.
- `done`  out  1  one-cycle pulse when HI/LO take a new product.
- `hi`  out  `WIDTH`  HI register.
- `lo`  out  `WIDTH`  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start` with op MULT/MULTU:
  - Latch operand magnitudes. For MULT, a negative operand is two's-complemented; 0x80000000 gives magnitude 0x80000000.
  - Latch `neg` = signed op and operand sign bits differ.
  - Clear the 64-bit accumulator, load a 6-bit counter with 32, go to RUN.
- RUN: radix-2 shift-add, one multiplier bit per cycle (LSB first); decrement counter. At count 0, go to FIX.
- FIX:
  - If `neg`, write the two's complement of the accumulator, otherwise the accumulator unchanged: upper half to `hi`, lower half to `lo`.
  - Pulse `done`, return to IDLE.
- IDLE, `start` with MTHI or MTLO: `hi` (or `lo`) takes `rs_val` at that edge. No state change, no `busy`, no `done`.
- `hi`/`lo` hold their previous values for the whole of RUN. Partial products are never visible.
- `start` while `busy` is ignored. Operands are not re-sampled and the operation is not queued.
- `flush` in RUN or FIX:
  - Return to IDLE at that edge; `busy` drops.
  - No `done`, and `hi`/`lo` keep their pre-issue values.
  - `flush` takes priority over FIX completion.
- `flush` in IDLE: no effect. `start` in the same cycle is still honoured.
- Arithmetic is modulo 2^64. Overflow cannot occur; there is no exception output.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
  - Reset mid-operation aborts the operation and zeroes HI/LO immediately.
- Issue on edge E0:
  - `busy`=1 from after E0 until after E33.
  - RUN occupies edges E1..E32; FIX is evaluated at E33.
  - `hi`/`lo` show the product and `done`=1 in the cycle after E33; `done` drops after E34.
- Total latency: 33 cycles from issue edge to visible result. `busy` and `done` are never high together.
- Back-to-back issue: a new `start` is accepted at E33+1, the first cycle `busy`=0.
- MTHI/MTLO: single cycle; the new value is visible in the cycle after the issue edge.

## Test plan
- MULT 3 × 5 (`rs_val`=0x00000003, `rt_val`=0x00000005):
  - `done` 33 cycles after issue.
  - `hi`=0x00000000, `lo`=0x0000000F.
  - `busy` high for exactly 33 cycles.
- Signedness:
  - MULT 0xFFFFFFFF × 0x00000001 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFF.
  - MULTU with the same operands → `hi`=0x00000000, `lo`=0xFFFFFFFF.
- Corner: MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
  - MULTU with the same operands gives the same result.
- Ignored issue: MTHI 0x12345678 issued in IDLE → `hi`=0x12345678 next cycle.
  - Then MULT 2 × 2, with `start` pulsed again (op MTLO, 0xDEADBEEF) at cycle 10 of RUN.
  - Required: the MTLO is ignored, and `hi` stays 0x12345678 until `done`.
  - Final `hi`=0x00000000, `lo`=0x00000004.
- Flush: MTLO 0x0000AAAA, then MULT 7 × 9, then `flush` at cycle 20.
  - Required: `busy` drops the next cycle, no `done`, and `lo` stays 0x0000AAAA.
  - A following MULT 7 × 9 completes with `lo`=0x0000003F.
- Reset: `rst_n` low asynchronously at cycle 15 of a MULT.
  - Required: `busy`=0, `done`=0, `hi`=`lo`=0 without waiting for a clock edge.
  - After release, a new MULT 6 × 7 gives `lo`=0x0000002A.
